sysid_boot_checker: RTL and testbench
=====================================

Name: sysid_boot_checker

Overview:
- Avalon-MM read master that sequences the system-ID slave after reset or on request.
- Reads word 0 (ID) and word 1 (build timestamp), compares both against build-time expected values, and publishes a sticky pass/fail status.
- Gates software boot (`boot_ok`) so firmware never runs against a mismatched hardware image.
- Sits between the reset controller and the system-ID slave's control port.

Parameters:
- EXPECTED_ID, 32'h65FF_E144, expected word at address 0
- EXPECTED_TS, 32'h0000_0000, expected word at address 1
- TIMEOUT_CYCLES, 255, max cycles a read may stall on `waitrequest`; range 1..65535
- MAX_RETRY, 2, extra full read sequences attempted after a timeout; range 0..7
- AUTO_START, 1, 1 = start one sequence automatically on first clock after reset release

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to (re)run the check; ignored while `busy`
- address  out  1  Avalon address to sysid slave (0 = ID, 1 = timestamp)
- read  out  1  Avalon read strobe
- readdata  in  32  Avalon read data
- waitrequest  in  1  Avalon waitrequest; read completes on `read && !waitrequest`
- busy  out  1  sequence in progress
- done  out  1  sticky: last sequence finished
- boot_ok  out  1  sticky: `done` and both words matched
- id_mismatch  out  1  sticky: ID word differed
- ts_mismatch  out  1  sticky: timestamp word differed
- timed_out  out  1  sticky: retries exhausted on timeout
- id_word  out  32  captured ID word
- ts_word  out  32  captured timestamp word

Behaviour:
- Reset state: all outputs 0, state IDLE, retry and timeout counters 0. Reset asserted mid-sequence aborts immediately, with no partial status.
- States: IDLE, RD_ID, RD_TS, EVAL, DONE.
- IDLE → RD_ID:
  - on `start=1`, or on the first cycle after reset release when AUTO_START=1;
  - entering RD_ID clears `done`, `boot_ok`, `id_mismatch`, `ts_mismatch` and `timed_out`;
  - `busy` goes high in the same cycle.
- RD_ID:
  - `read=1`, `address=0`;
  - on `!waitrequest`, `readdata` is captured into `id_word` and the FSM moves to RD_TS;
  - `read` drops for exactly one cycle between the two reads.
- RD_TS:
  - `read=1`, `address=1`;
  - on `!waitrequest`, `readdata` is captured into `ts_word` and the FSM moves to EVAL.
- Timeout:
  - a 16-bit stall counter resets on entry to each read state and increments each cycle `waitrequest=1`;
  - when it reaches TIMEOUT_CYCLES, the read is abandoned (`read` deasserted next cycle);
  - if retry_count < MAX_RETRY: retry_count++ and return to RD_ID;
  - otherwise set `timed_out=1` and go to DONE.
- EVAL (1 cycle):
  - `id_mismatch = (id_word != EXPECTED_ID)`;
  - `ts_mismatch = (ts_word != EXPECTED_TS)`;
  - → DONE.
- DONE (1 cycle):
  - `done=1`;
  - `boot_ok = !id_mismatch && !ts_mismatch && !timed_out`;
  - `busy=0`, retry_count cleared;
  - → IDLE.
- Latency with zero wait states, start to `done` = 5 cycles (RD_ID, gap, RD_TS, EVAL, DONE).
- Handshake: `read` and `address` are held stable while `waitrequest=1`.
- A `start` pulse while `busy` is dropped, not queued.
- A `start` pulse in the same cycle as DONE is dropped.
- A mismatch does not trigger a retry; only timeouts are retried.
- Status flags remain stable in IDLE until the next start.

Optional Feature:
- Macro: SYSID_BOOT_CHECKER_IRQ_EN.
- When defined:
  - adds input `irq_ack` (1 bit) and output `irq` (1 bit);
  - `irq` sets in the DONE cycle when `boot_ok=0`;
  - `irq` stays high until `irq_ack=1` (cleared next cycle) or reset;
  - if a set and an ack occur in the same cycle, set wins.
- When undefined: neither port exists, and no failure notification is produced other than the status flags.

Test Plan:
- AUTO_START=1, slave returns 32'h65FF_E144 / 32'h0, no waits → `done` and `boot_ok` = 1 on cycle 5 after reset release; `id_word` = 32'h65FF_E144.
- Slave returns ID 32'h1234_5678 → `done=1`, `boot_ok=0`, `id_mismatch=1`, `ts_mismatch=0`; no retry observed (exactly 2 reads).
- `waitrequest` held 3 cycles on each read → `address` and `read` stable throughout; `boot_ok=1` at 11 cycles.
- TIMEOUT_CYCLES=4, MAX_RETRY=2, `waitrequest` stuck high → 3 RD_ID attempts of 4 stall cycles each, then `timed_out=1`, `boot_ok=0`.
- `start` pulsed while `busy`, then again after `done` → first pulse ignored; second pulse clears the flags and reruns.
- `reset_n` asserted during RD_TS → all outputs 0 immediately; with the IRQ macro defined, a failure raises `irq`, and `irq_ack` clears it next cycle.

Source files
------------

// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads the sysid slave's ID and timestamp words over Avalon-MM and publishes sticky pass/fail status.
// Optional failure interrupt (irq/irq_ack) is enabled by defining SYSID_BOOT_CHECKER_IRQ_EN.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h65FF_E144,
  parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRY      = 2,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic        busy,
  output logic        done,
  output logic        boot_ok,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timed_out,
  output logic [31:0] id_word,
  output logic [31:0] ts_word
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
  ,
  input  logic        irq_ack,
  output logic        irq
`endif
);

  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  RETRY_LIMIT = 3'(MAX_RETRY);

  // S_GAP is the one idle-bus cycle between reads, and also before a retried ID read.
  typedef enum logic [2:0] {S_IDLE, S_RD_ID, S_GAP, S_RD_TS, S_EVAL, S_DONE} state_t;

  state_t      state;
  logic [15:0] stall_cnt;
  logic [2:0]  retry_cnt;
  logic        gap_to_ts;
  logic        auto_go;
  logic        id_bad;
  logic        ts_bad;

  assign id_bad = (id_word != EXPECTED_ID);
  assign ts_bad = (ts_word != EXPECTED_TS);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      stall_cnt   <= '0;
      retry_cnt   <= '0;
      gap_to_ts   <= 1'b0;
      auto_go     <= AUTO_START;
      address     <= 1'b0;
      read        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      boot_ok     <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timed_out   <= 1'b0;
      id_word     <= '0;
      ts_word     <= '0;
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
      irq         <= 1'b0;
`endif
    end else begin
      auto_go <= 1'b0;
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
      // An ack is overridden by a set later in this block in the same cycle.
      if (irq_ack) irq <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (start || auto_go) begin
            state       <= S_RD_ID;
            busy        <= 1'b1;
            read        <= 1'b1;
            address     <= 1'b0;
            stall_cnt   <= '0;
            retry_cnt   <= '0;
            done        <= 1'b0;
            boot_ok     <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timed_out   <= 1'b0;
          end
        end
        S_RD_ID, S_RD_TS: begin
          if (!waitrequest) begin
            read      <= 1'b0;
            stall_cnt <= '0;
            if (state == S_RD_ID) begin
              id_word   <= readdata;
              gap_to_ts <= 1'b1;
              state     <= S_GAP;
            end else begin
              ts_word <= readdata;
              state   <= S_EVAL;
            end
          end else if (stall_cnt == STALL_LIMIT) begin
            read      <= 1'b0;
            stall_cnt <= '0;
            if (retry_cnt < RETRY_LIMIT) begin
              retry_cnt <= retry_cnt + 3'd1;
              gap_to_ts <= 1'b0;
              state     <= S_GAP;
            end else begin
              timed_out <= 1'b1;
              done      <= 1'b1;
              boot_ok   <= 1'b0;
              busy      <= 1'b0;
              state     <= S_DONE;
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
              irq       <= 1'b1;
`endif
            end
          end else begin
            stall_cnt <= stall_cnt + 16'd1;
          end
        end
        S_GAP: begin
          read      <= 1'b1;
          address   <= gap_to_ts;
          stall_cnt <= '0;
          state     <= gap_to_ts ? S_RD_TS : S_RD_ID;
        end
        S_EVAL: begin
          id_mismatch <= id_bad;
          ts_mismatch <= ts_bad;
          done        <= 1'b1;
          boot_ok     <= !id_bad && !ts_bad && !timed_out;
          busy        <= 1'b0;
          state       <= S_DONE;
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
          if (id_bad || ts_bad || timed_out) irq <= 1'b1;
`endif
        end
        S_DONE: begin
          retry_cnt <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Self-checking bench for sysid_boot_checker: randomized sysid slave stall/data plans checked against a transaction-level outcome model.
// Also exercises the IRQ ports when SYSID_BOOT_CHECKER_IRQ_EN is defined.
module tb_sysid_boot_checker;

  localparam logic [31:0] EXP_ID  = 32'h65FF_E144;
  localparam logic [31:0] EXP_TS  = 32'h0000_0000;
  localparam int          TIMEOUT = 4;
  localparam int          RETRIES = 2;
  localparam int          BUDGET  = 200;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        address;
  logic        read;
  logic [31:0] readdata = '0;
  logic        waitrequest = 1'b0;
  logic        busy, done, boot_ok, id_mismatch, ts_mismatch, timed_out;
  logic [31:0] id_word, ts_word;
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
  logic        irq_ack = 1'b0;
  logic        irq;
`endif

  int checks = 0;
  int failures = 0;

  sysid_boot_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(TIMEOUT),
    .MAX_RETRY(RETRIES), .AUTO_START(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .address(address), .read(read),
    .readdata(readdata), .waitrequest(waitrequest), .busy(busy), .done(done),
    .boot_ok(boot_ok), .id_mismatch(id_mismatch), .ts_mismatch(ts_mismatch),
    .timed_out(timed_out), .id_word(id_word), .ts_word(ts_word)
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
    , .irq_ack(irq_ack), .irq(irq)
`endif
  );

  always #5 clock = ~clock;

  // Slave model: each new read transaction pops its stall length from plan_q.
  int          plan_q[$];
  logic [31:0] id_data = EXP_ID;
  logic [31:0] ts_data = EXP_TS;
  int          reads_seen = 0;
  int          stalls_seen = 0;
  int          addr_glitch = 0;
  bit          in_txn = 1'b0;
  logic        txn_addr = 1'b0;
  int          remaining = 0;

  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_txn = 1'b0;
      remaining = 0;
      waitrequest = 1'b0;
    end else if (!read) begin
      in_txn = 1'b0;
      waitrequest = 1'b0;
    end else begin
      if (!in_txn) begin
        in_txn = 1'b1;
        txn_addr = address;
        remaining = 0;
        if (plan_q.size() > 0) remaining = plan_q.pop_front();
        reads_seen++;
      end else if (address !== txn_addr) begin
        addr_glitch++;
      end
      readdata = address ? ts_data : id_data;
      if (remaining > 0) begin
        waitrequest = 1'b1;
        remaining--;
        stalls_seen++;
      end else begin
        waitrequest = 1'b0;
      end
    end
  end

  // Outcome model: walks the stall plan attempt by attempt and totals cycles.
  int          plan_arr[8];
  int          exp_lat, exp_reads, exp_stalls;
  bit          exp_to, exp_idmm, exp_tsmm, exp_ok;
  logic [31:0] exp_id_word = '0;
  logic [31:0] exp_ts_word = '0;

  function automatic void predict();
    int idx, lat, st, s;
    bit ok;
    idx = 0; lat = 0; st = 0; ok = 1'b0;
    for (int a = 0; a <= RETRIES; a++) begin
      s = plan_arr[idx]; idx++;
      if (s >= TIMEOUT) begin
        lat += TIMEOUT; st += TIMEOUT;
        if (a != RETRIES) lat += 1;
        continue;
      end
      lat += s + 2; st += s; exp_id_word = id_data;
      s = plan_arr[idx]; idx++;
      if (s >= TIMEOUT) begin
        lat += TIMEOUT; st += TIMEOUT;
        if (a != RETRIES) lat += 1;
        continue;
      end
      lat += s + 2; st += s; exp_ts_word = ts_data;
      ok = 1'b1;
      break;
    end
    exp_lat = lat + 1;
    exp_reads = idx;
    exp_stalls = st;
    exp_to = !ok;
    exp_idmm = ok && (id_data != EXP_ID);
    exp_tsmm = ok && (ts_data != EXP_TS);
    exp_ok = ok && !exp_idmm && !exp_tsmm;
  endfunction

  task automatic load_plan(input int n);
    plan_q.delete();
    for (int i = 0; i < n; i++) plan_q.push_back(plan_arr[i]);
  endtask

  task automatic set_plan(input int s);
    for (int i = 0; i < 8; i++) plan_arr[i] = s;
  endtask

  task automatic wait_done(input int start_lat, output int lat);
    lat = start_lat;
    while (done !== 1'b1 && lat < BUDGET) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic run_seq(output int lat);
    repeat (2) @(negedge clock);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(1, lat);
  endtask

  task automatic test_reset();
    int lat;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({address, read, busy, done, boot_ok, id_mismatch, ts_mismatch, timed_out, id_word, ts_word} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b read=%b id=%h ts=%h, expected all zero",
               busy, done, read, id_word, ts_word);
    end
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin failures++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
`endif
    id_data = EXP_ID; ts_data = EXP_TS;
    set_plan(0); predict(); load_plan(8);
    reset_n = 1'b1;
    wait_done(0, lat);
    checks++;
    if (lat !== exp_lat) begin failures++; $display("[TB] FAIL auto_start_latency: got %0d expected %0d", lat, exp_lat); end
    checks++;
    if (boot_ok !== 1'b1) begin failures++; $display("[TB] FAIL auto_start_boot_ok: got %b expected 1", boot_ok); end
    checks++;
    if (id_word !== EXP_ID) begin failures++; $display("[TB] FAIL auto_start_id_word: got %h expected %h", id_word, EXP_ID); end
  endtask

  task automatic test_id_mismatch();
    int lat, r0;
    id_data = 32'h1234_5678; ts_data = EXP_TS;
    set_plan(0); predict(); load_plan(8);
    r0 = reads_seen;
    run_seq(lat);
    checks++;
    if ({done, boot_ok, id_mismatch, ts_mismatch} !== {1'b1, exp_ok, exp_idmm, exp_tsmm}) begin
      failures++;
      $display("[TB] FAIL id_mismatch_flags: got done/ok/idmm/tsmm=%b%b%b%b expected 1%b%b%b",
               done, boot_ok, id_mismatch, ts_mismatch, exp_ok, exp_idmm, exp_tsmm);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (reads_seen - r0 !== exp_reads) begin
      failures++; $display("[TB] FAIL id_mismatch_reads: got %0d expected %0d", reads_seen - r0, exp_reads);
    end
  endtask

  task automatic test_wait_states();
    int lat, g0;
    id_data = EXP_ID; ts_data = EXP_TS;
    set_plan(3); predict(); load_plan(8);
    g0 = addr_glitch;
    run_seq(lat);
    checks++;
    if (lat !== exp_lat) begin failures++; $display("[TB] FAIL wait_latency: got %0d expected %0d", lat, exp_lat); end
    checks++;
    if (boot_ok !== 1'b1) begin failures++; $display("[TB] FAIL wait_boot_ok: got %b expected 1", boot_ok); end
    checks++;
    if (addr_glitch !== g0) begin failures++; $display("[TB] FAIL wait_addr_stable: got %0d changes expected 0", addr_glitch - g0); end
  endtask

  task automatic test_timeout();
    int lat, r0, s0;
    set_plan(50); predict(); load_plan(8);
    r0 = reads_seen; s0 = stalls_seen;
    run_seq(lat);
    checks++;
    if (lat !== exp_lat) begin failures++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", lat, exp_lat); end
    checks++;
    if ({timed_out, boot_ok} !== 2'b10) begin failures++; $display("[TB] FAIL timeout_flags: got to/ok=%b%b expected 10", timed_out, boot_ok); end
    repeat (3) @(negedge clock);
    checks++;
    if (reads_seen - r0 !== 3 || stalls_seen - s0 !== 3 * TIMEOUT) begin
      failures++;
      $display("[TB] FAIL timeout_attempts: got reads=%0d stalls=%0d expected reads=3 stalls=%0d",
               reads_seen - r0, stalls_seen - s0, 3 * TIMEOUT);
    end
  endtask

  task automatic test_start_while_busy();
    int lat, r0;
    id_data = EXP_ID; ts_data = EXP_TS;
    set_plan(0); predict(); load_plan(8);
    r0 = reads_seen;
    repeat (2) @(negedge clock);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL busy_after_start: got %b expected 1", busy); end
    @(negedge clock);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(2, lat);
    checks++;
    if (lat !== exp_lat) begin failures++; $display("[TB] FAIL busy_start_latency: got %0d expected %0d", lat, exp_lat); end
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if ({busy, done, boot_ok} !== 3'b011 || reads_seen - r0 !== 2) begin
      failures++;
      $display("[TB] FAIL start_dropped: got busy/done/ok=%b%b%b reads=%0d expected 011 reads=2",
               busy, done, boot_ok, reads_seen - r0);
    end
    id_data = 32'hDEAD_0001;
    predict(); load_plan(8);
    run_seq(lat);
    checks++;
    if (id_mismatch !== 1'b1) begin failures++; $display("[TB] FAIL rerun_mismatch: got %b expected 1", id_mismatch); end
    id_data = EXP_ID;
    predict(); load_plan(8);
    repeat (2) @(negedge clock);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    checks++;
    if ({done, id_mismatch, busy} !== 3'b001) begin
      failures++; $display("[TB] FAIL rerun_clears: got done/idmm/busy=%b%b%b expected 001", done, id_mismatch, busy);
    end
    wait_done(1, lat);
    checks++;
    if (boot_ok !== 1'b1) begin failures++; $display("[TB] FAIL rerun_boot_ok: got %b expected 1", boot_ok); end
  endtask

  task automatic test_random();
    int lat, r0, s0, g0;
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 8; i++) plan_arr[i] = $urandom_range(0, 5);
      id_data = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
      ts_data = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
      predict(); load_plan(8);
      r0 = reads_seen; s0 = stalls_seen; g0 = addr_glitch;
      run_seq(lat);
      checks++;
      if (lat !== exp_lat) begin failures++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", n, lat, exp_lat); end
      checks++;
      if ({timed_out, boot_ok, id_mismatch, ts_mismatch} !== {exp_to, exp_ok, exp_idmm, exp_tsmm}) begin
        failures++;
        $display("[TB] FAIL rand%0d_flags: got to/ok/idmm/tsmm=%b%b%b%b expected %b%b%b%b", n,
                 timed_out, boot_ok, id_mismatch, ts_mismatch, exp_to, exp_ok, exp_idmm, exp_tsmm);
      end
      checks++;
      if (id_word !== exp_id_word || ts_word !== exp_ts_word) begin
        failures++;
        $display("[TB] FAIL rand%0d_words: got %h/%h expected %h/%h", n, id_word, ts_word, exp_id_word, exp_ts_word);
      end
      repeat (2) @(negedge clock);
      checks++;
      if (reads_seen - r0 !== exp_reads || stalls_seen - s0 !== exp_stalls || addr_glitch !== g0) begin
        failures++;
        $display("[TB] FAIL rand%0d_bus: got reads=%0d stalls=%0d glitches=%0d expected %0d/%0d/0", n,
                 reads_seen - r0, stalls_seen - s0, addr_glitch - g0, exp_reads, exp_stalls);
      end
    end
  endtask

  task automatic test_reset_mid_sequence();
    int lat, cyc;
    id_data = EXP_ID; ts_data = EXP_TS;
    plan_arr[0] = 0; plan_arr[1] = 3;
    load_plan(2);
    repeat (2) @(negedge clock);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 0;
    while (!(read === 1'b1 && address === 1'b1) && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    checks++;
    if (cyc >= 20) begin failures++; $display("[TB] FAIL reach_rd_ts: got no TS read within %0d cycles expected one", cyc); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({address, read, busy, done, boot_ok, id_mismatch, ts_mismatch, timed_out, id_word, ts_word} !== '0) begin
      failures++;
      $display("[TB] FAIL mid_reset_outputs: got busy=%b read=%b addr=%b id=%h expected all zero",
               busy, read, address, id_word);
    end
    exp_id_word = '0; exp_ts_word = '0;
    set_plan(0); predict(); load_plan(8);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    wait_done(0, lat);
    checks++;
    if (lat !== exp_lat || boot_ok !== 1'b1) begin
      failures++; $display("[TB] FAIL mid_reset_rerun: got lat=%0d ok=%b expected lat=%0d ok=1", lat, boot_ok, exp_lat);
    end
  endtask

`ifdef SYSID_BOOT_CHECKER_IRQ_EN
  task automatic test_irq();
    int lat;
    id_data = EXP_ID; ts_data = 32'h0BAD_0BAD;
    set_plan(0); predict(); load_plan(8);
    run_seq(lat);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("[TB] FAIL irq_set: got %b expected 1", irq); end
    repeat (3) @(negedge clock);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("[TB] FAIL irq_hold: got %b expected 1", irq); end
    irq_ack = 1'b1;
    @(posedge clock); #1;
    irq_ack = 1'b0;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("[TB] FAIL irq_ack_clear: got %b expected 0", irq); end
    ts_data = EXP_TS;
    predict(); load_plan(8);
    run_seq(lat);
    @(negedge clock);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("[TB] FAIL irq_on_pass: got %b expected 0", irq); end
  endtask
`endif

  initial begin
    test_reset();
    test_id_mismatch();
    test_wait_states();
    test_timeout();
    test_start_while_busy();
    test_random();
    test_reset_mid_sequence();
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
    test_irq();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
